inst_rom_loader: RTL and testbench

- Instruction-memory responder for the core's fetch port: answers rom_ce/rom_addr with the instruction word in the same cycle.
- Contents are loaded at boot from a byte-wide valid/ready stream (UART/debug bridge side).
- Holds the core in reset until the load completes.
- Sits at top level beside the core, on the other end of the core's rom_addr_o/rom_ce_o/rom_data_i.

---
 rtl/inst_rom_loader_pkg.sv | 35 +++
 rtl/inst_mem_1w1r.sv | 61 ++++++
 rtl/inst_rom_loader.sv | 188 ++++++++++++++++++
 tb/tb_inst_rom_loader.sv | 332 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/inst_rom_loader_pkg.sv
// -----------------------------------------------------------------------------
// inst_rom_loader_pkg
// Shared definitions for the boot-time instruction ROM loader:
//   - fetch-port bus widths (register bus / instruction address bus)
//   - loader word-count width
//   - loader FSM state encoding
//   - big-endian byte assembly helper
// -----------------------------------------------------------------------------
package inst_rom_loader_pkg;

    // 32-bit fetch port widths shared with the core
    localparam int REG_BUS_W       = 32;
    localparam int INST_ADDR_BUS_W = 32;

    // Width of the word count carried in the stream header
    localparam int WCNT_W = 16;

    // Loader FSM states
    typedef enum logic [1:0] {
        LDR_HDR_HI = 2'd0,
        LDR_HDR_LO = 2'd1,
        LDR_DATA   = 2'd2,
        LDR_RUN    = 2'd3
    } ldr_state_e;

    // Shift one stream byte into a big-endian word: the first byte received
    // ends up in bits 31:24 after four shifts.
    function automatic logic [REG_BUS_W-1:0] shift_in_byte(
        input logic [REG_BUS_W-1:0] acc,
        input logic [7:0]           b
    );
        return {acc[REG_BUS_W-9:0], b};
    endfunction

endpackage : inst_rom_loader_pkg

// File: rtl/inst_mem_1w1r.sv
// -----------------------------------------------------------------------------
// inst_mem_1w1r
// DEPTH x 32 instruction memory with one synchronous write port and one
// combinational read port. The read port decodes a byte address: bits [1:0]
// are ignored, bits [AW+1:2] select the word, and any set bit above AW+1 or a
// word index >= DEPTH returns zero. Contents are never cleared.
// Ports:
//   clk    - write clock
//   we     - write enable (write on rising edge)
//   waddr  - word index for writes (caller guarantees < DEPTH)
//   wdata  - write data
//   re     - read enable; rdata is 0 when low
//   raddr  - read byte address
//   rdata  - read data
// -----------------------------------------------------------------------------
module inst_mem_1w1r
    import inst_rom_loader_pkg::*;
#(
    parameter int DEPTH = 1024,
    parameter int AW    = 10
) (
    input  logic                       clk,
    input  logic                       we,
    input  logic [AW-1:0]              waddr,
    input  logic [REG_BUS_W-1:0]       wdata,
    input  logic                       re,
    input  logic [INST_ADDR_BUS_W-1:0] raddr,
    output logic [REG_BUS_W-1:0]       rdata
);

    localparam logic [AW:0] DEPTH_V = (AW+1)'(DEPTH);

    logic [REG_BUS_W-1:0] mem_r [0:DEPTH-1];

    logic [AW-1:0] ridx_s;
    logic          hi_zero_s;
    logic          in_range_s;
    logic          unused_s;

    assign ridx_s    = raddr[AW+1:2];
    assign hi_zero_s = (raddr[INST_ADDR_BUS_W-1:AW+2] == '0);
    assign unused_s  = &{1'b0, raddr[1:0]};

    // Write port: memory has no reset so contents survive a reload reset
    always_ff @(posedge clk) begin
        if (we) begin
            mem_r[waddr] <= wdata;
        end
    end

    // Read port: zero-latency lookup with out-of-range and disable gating
    always_comb begin
        in_range_s = hi_zero_s && ({1'b0, ridx_s} < DEPTH_V);
        if (re && in_range_s) begin
            rdata = mem_r[ridx_s];
        end else begin
            rdata = {REG_BUS_W{1'b0}};
        end
    end

endmodule : inst_mem_1w1r

// File: rtl/inst_rom_loader.sv
// -----------------------------------------------------------------------------
// inst_rom_loader
// Boot loader and instruction-memory responder for the core's fetch port.
// A byte stream (16-bit big-endian word count N, then 4N big-endian bytes)
// fills the memory; the core is held in reset until the load finishes.
// Ports:
//   clk            - system clock
//   rst            - asynchronous active-low reset
//   rom_ce_i       - fetch enable from core
//   rom_addr_i     - fetch byte address (pc)
//   rom_data_o     - fetched instruction (combinational)
//   ld_valid_i     - load byte valid
//   ld_data_i      - load byte
//   ld_ready_o     - loader accepts a byte (registered)
//   cpu_rst_o      - active-high core reset, high while loading (registered)
//   load_done_o    - load complete (registered)
//   words_loaded_o - words written into memory since reset (saturates at DEPTH)
// -----------------------------------------------------------------------------
module inst_rom_loader
    import inst_rom_loader_pkg::*;
#(
    parameter int DEPTH = 1024,
    parameter int AW    = 10
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       rom_ce_i,
    input  logic [INST_ADDR_BUS_W-1:0] rom_addr_i,
    output logic [REG_BUS_W-1:0]       rom_data_o,
    input  logic                       ld_valid_i,
    input  logic [7:0]                 ld_data_i,
    output logic                       ld_ready_o,
    output logic                       cpu_rst_o,
    output logic                       load_done_o,
    output logic [WCNT_W-1:0]          words_loaded_o
);

    localparam logic [WCNT_W:0] DEPTH_W = (WCNT_W+1)'(DEPTH);

    ldr_state_e           state_r, state_s;
    logic [WCNT_W-1:0]    hdr_r, hdr_s;
    logic [WCNT_W-1:0]    ptr_r, ptr_s;
    logic [1:0]           byte_idx_r, byte_idx_s;
    logic [REG_BUS_W-1:0] asm_r, asm_s;
    logic [WCNT_W-1:0]    words_r, words_s;
    logic                 ld_ready_r, ld_ready_s;
    logic                 cpu_rst_r, cpu_rst_s;
    logic                 load_done_r, load_done_s;

    logic                 xfer_s;
    logic                 we_s;
    logic [REG_BUS_W-1:0] wdata_s;
    logic [WCNT_W-1:0]    ptr_inc_s;

    // A byte moves only when the registered ready is high; ready is low in RUN
    assign xfer_s    = ld_valid_i & ld_ready_r;
    assign ptr_inc_s = ptr_r + 16'd1;

    // State register and registered outputs
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r     <= LDR_HDR_HI;
            hdr_r       <= 16'd0;
            ptr_r       <= 16'd0;
            byte_idx_r  <= 2'd0;
            asm_r       <= 32'd0;
            words_r     <= 16'd0;
            ld_ready_r  <= 1'b1;
            cpu_rst_r   <= 1'b1;
            load_done_r <= 1'b0;
        end else begin
            state_r     <= state_s;
            hdr_r       <= hdr_s;
            ptr_r       <= ptr_s;
            byte_idx_r  <= byte_idx_s;
            asm_r       <= asm_s;
            words_r     <= words_s;
            ld_ready_r  <= ld_ready_s;
            cpu_rst_r   <= cpu_rst_s;
            load_done_r <= load_done_s;
        end
    end

    // Next-state logic: header capture, byte assembly, word write and counters
    always_comb begin
        state_s    = state_r;
        hdr_s      = hdr_r;
        ptr_s      = ptr_r;
        byte_idx_s = byte_idx_r;
        asm_s      = asm_r;
        words_s    = words_r;
        we_s       = 1'b0;
        wdata_s    = 32'd0;
        case (state_r)
            LDR_HDR_HI: begin
                if (xfer_s) begin
                    hdr_s   = {ld_data_i, 8'd0};
                    state_s = LDR_HDR_LO;
                end else begin
                    state_s = LDR_HDR_HI;
                end
            end
            LDR_HDR_LO: begin
                if (xfer_s) begin
                    hdr_s      = {hdr_r[15:8], ld_data_i};
                    ptr_s      = 16'd0;
                    byte_idx_s = 2'd0;
                    if ({hdr_r[15:8], ld_data_i} == 16'd0) begin
                        state_s = LDR_RUN;
                    end else begin
                        state_s = LDR_DATA;
                    end
                end else begin
                    state_s = LDR_HDR_LO;
                end
            end
            LDR_DATA: begin
                if (xfer_s) begin
                    asm_s      = shift_in_byte(asm_r, ld_data_i);
                    byte_idx_s = byte_idx_r + 2'd1;
                    if (byte_idx_r == 2'd3) begin
                        wdata_s = asm_s;
                        // Words beyond the array are consumed but dropped
                        if ({1'b0, ptr_r} < DEPTH_W) begin
                            we_s = 1'b1;
                            if ({1'b0, words_r} < DEPTH_W) begin
                                words_s = words_r + 16'd1;
                            end else begin
                                words_s = words_r;
                            end
                        end else begin
                            we_s = 1'b0;
                        end
                        ptr_s = ptr_inc_s;
                        if (ptr_inc_s == hdr_r) begin
                            state_s = LDR_RUN;
                        end else begin
                            state_s = LDR_DATA;
                        end
                    end else begin
                        state_s = LDR_DATA;
                    end
                end else begin
                    state_s = LDR_DATA;
                end
            end
            LDR_RUN: begin
                state_s = LDR_RUN;
            end
            default: begin
                state_s = LDR_HDR_HI;
            end
        endcase
    end

    // Output decode from the next state so the registered outputs switch on
    // the same edge that enters RUN
    always_comb begin
        if (state_s == LDR_RUN) begin
            ld_ready_s  = 1'b0;
            cpu_rst_s   = 1'b0;
            load_done_s = 1'b1;
        end else begin
            ld_ready_s  = 1'b1;
            cpu_rst_s   = 1'b1;
            load_done_s = 1'b0;
        end
    end

    inst_mem_1w1r #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_mem (
        .clk   (clk),
        .we    (we_s),
        .waddr (ptr_r[AW-1:0]),
        .wdata (wdata_s),
        .re    (rom_ce_i),
        .raddr (rom_addr_i),
        .rdata (rom_data_o)
    );

    assign ld_ready_o     = ld_ready_r;
    assign cpu_rst_o      = cpu_rst_r;
    assign load_done_o    = load_done_r;
    assign words_loaded_o = words_r;

endmodule : inst_rom_loader

// File: tb/tb_inst_rom_loader.sv
// -----------------------------------------------------------------------------
// tb_inst_rom_loader
// Directed bench for inst_rom_loader. A full-size instance (DEPTH=1024) and a
// small instance (DEPTH=4) share clock and reset; each has its own stream and
// fetch signals.
// -----------------------------------------------------------------------------
module tb_inst_rom_loader;

    logic        clk;
    logic        rst;

    logic        ce_a, ce_b;
    logic [31:0] addr_a, addr_b;
    logic [31:0] data_a, data_b;
    logic        vld_a, vld_b;
    logic [7:0]  byte_a, byte_b;
    logic        rdy_a, rdy_b;
    logic        crst_a, crst_b;
    logic        done_a, done_b;
    logic [15:0] words_a, words_b;

    int tests_run;
    int tests_failed;

    inst_rom_loader #(.DEPTH(1024), .AW(10)) dut_a (
        .clk            (clk),
        .rst            (rst),
        .rom_ce_i       (ce_a),
        .rom_addr_i     (addr_a),
        .rom_data_o     (data_a),
        .ld_valid_i     (vld_a),
        .ld_data_i      (byte_a),
        .ld_ready_o     (rdy_a),
        .cpu_rst_o      (crst_a),
        .load_done_o    (done_a),
        .words_loaded_o (words_a)
    );

    inst_rom_loader #(.DEPTH(4), .AW(2)) dut_b (
        .clk            (clk),
        .rst            (rst),
        .rom_ce_i       (ce_b),
        .rom_addr_i     (addr_b),
        .rom_data_o     (data_b),
        .ld_valid_i     (vld_b),
        .ld_data_i      (byte_b),
        .ld_ready_o     (rdy_b),
        .cpu_rst_o      (crst_b),
        .load_done_o    (done_b),
        .words_loaded_o (words_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Send one byte to instance A (sel=0) or B (sel=1); leaves valid low after
    task automatic send_byte(input bit sel, input logic [7:0] b);
        @(negedge clk);
        if (sel) begin
            vld_b = 1'b1; byte_b = b;
            if (rdy_b !== 1'b1) begin
                tests_run++; tests_failed++;
                $display("FAIL send_b: ready=%b required 1 for byte %02h", rdy_b, b);
            end
        end else begin
            vld_a = 1'b1; byte_a = b;
            if (rdy_a !== 1'b1) begin
                tests_run++; tests_failed++;
                $display("FAIL send_a: ready=%b required 1 for byte %02h", rdy_a, b);
            end
        end
        @(posedge clk);
        #1;
        vld_a = 1'b0;
        vld_b = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic read_a(input logic ce, input logic [31:0] a);
        @(negedge clk);
        ce_a = ce; addr_a = a;
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        #12;
        tests_run++;
        if ({rdy_a, crst_a, done_a} !== 3'b110 || words_a !== 16'd0) begin
            tests_failed++;
            $display("FAIL reset_state: rdy/crst/done=%b words=%0d required 110 / 0",
                     {rdy_a, crst_a, done_a}, words_a);
        end
        @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic test_basic_load();
        logic [7:0] s [10] = '{8'h00, 8'h02, 8'h34, 8'h01, 8'h00, 8'h05,
                               8'h00, 8'h00, 8'h00, 8'h00};
        for (int i = 0; i < 9; i++) send_byte(1'b0, s[i]);
        tests_run++;
        if (done_a !== 1'b0 || crst_a !== 1'b1 || words_a !== 16'd1) begin
            tests_failed++;
            $display("FAIL basic_before_last: done=%b crst=%b words=%0d required 0 1 1",
                     done_a, crst_a, words_a);
        end
        send_byte(1'b0, s[9]);
        tests_run++;
        if (done_a !== 1'b1 || crst_a !== 1'b0 || rdy_a !== 1'b0 || words_a !== 16'd2) begin
            tests_failed++;
            $display("FAIL basic_done: done=%b crst=%b rdy=%b words=%0d required 1 0 0 2",
                     done_a, crst_a, rdy_a, words_a);
        end
        read_a(1'b1, 32'h0);
        tests_run++;
        if (data_a !== 32'h34010005) begin
            tests_failed++;
            $display("FAIL basic_rd0: got %08h required 34010005", data_a);
        end
        read_a(1'b1, 32'h3);
        tests_run++;
        if (data_a !== 32'h34010005) begin
            tests_failed++;
            $display("FAIL basic_rd3: got %08h required 34010005", data_a);
        end
        read_a(1'b1, 32'h4);
        tests_run++;
        if (data_a !== 32'h0) begin
            tests_failed++;
            $display("FAIL basic_rd4: got %08h required 00000000", data_a);
        end
        read_a(1'b1, 32'h6);
        tests_run++;
        if (data_a !== 32'h0) begin
            tests_failed++;
            $display("FAIL basic_rd6: got %08h required 00000000", data_a);
        end
    endtask

    task automatic test_ce_gate();
        read_a(1'b0, 32'h0);
        tests_run++;
        if (data_a !== 32'h0) begin
            tests_failed++;
            $display("FAIL ce_low: got %08h required 00000000", data_a);
        end
        read_a(1'b1, 32'h8000_0000);
        tests_run++;
        if (data_a !== 32'h0) begin
            tests_failed++;
            $display("FAIL high_addr: got %08h required 00000000", data_a);
        end
        read_a(1'b1, 32'h0000_1000);
        tests_run++;
        if (data_a !== 32'h0) begin
            tests_failed++;
            $display("FAIL addr_bit12: got %08h required 00000000", data_a);
        end
    endtask

    task automatic test_empty_header();
        do_reset();
        send_byte(1'b0, 8'h00);
        tests_run++;
        if (done_a !== 1'b0 || rdy_a !== 1'b1) begin
            tests_failed++;
            $display("FAIL empty_mid: done=%b rdy=%b required 0 1", done_a, rdy_a);
        end
        send_byte(1'b0, 8'h00);
        tests_run++;
        if (done_a !== 1'b1 || crst_a !== 1'b0 || rdy_a !== 1'b0 || words_a !== 16'd0) begin
            tests_failed++;
            $display("FAIL empty_run: done=%b crst=%b rdy=%b words=%0d required 1 0 0 0",
                     done_a, crst_a, rdy_a, words_a);
        end
        @(negedge clk);
        vld_a = 1'b1; byte_a = 8'hAA;
        repeat (6) @(negedge clk);
        vld_a = 1'b0;
        tests_run++;
        if (rdy_a !== 1'b0 || done_a !== 1'b1 || words_a !== 16'd0) begin
            tests_failed++;
            $display("FAIL empty_ignore: rdy=%b done=%b words=%0d required 0 1 0",
                     rdy_a, done_a, words_a);
        end
        read_a(1'b1, 32'h0);
        tests_run++;
        if (data_a !== 32'h34010005) begin
            tests_failed++;
            $display("FAIL empty_mem_kept: got %08h required 34010005", data_a);
        end
    endtask

    task automatic test_gapped_load();
        logic [7:0] pre [6] = '{8'h00, 8'h01, 8'h11, 8'h22, 8'h33, 8'h44};
        logic [7:0] s [10]  = '{8'h00, 8'h02, 8'h34, 8'h01, 8'h00, 8'h05,
                                8'h00, 8'h00, 8'h00, 8'h00};
        do_reset();
        for (int i = 0; i < 6; i++) send_byte(1'b0, pre[i]);
        read_a(1'b1, 32'h0);
        tests_run++;
        if (data_a !== 32'h11223344 || words_a !== 16'd1) begin
            tests_failed++;
            $display("FAIL gap_pre: got %08h words=%0d required 11223344 1", data_a, words_a);
        end
        do_reset();
        for (int i = 0; i < 10; i++) begin
            repeat ($urandom_range(0, 4)) @(negedge clk);
            send_byte(1'b0, s[i]);
        end
        tests_run++;
        if (done_a !== 1'b1 || crst_a !== 1'b0 || words_a !== 16'd2) begin
            tests_failed++;
            $display("FAIL gap_done: done=%b crst=%b words=%0d required 1 0 2",
                     done_a, crst_a, words_a);
        end
        read_a(1'b1, 32'h0);
        tests_run++;
        if (data_a !== 32'h34010005) begin
            tests_failed++;
            $display("FAIL gap_rd0: got %08h required 34010005", data_a);
        end
        read_a(1'b1, 32'h4);
        tests_run++;
        if (data_a !== 32'h0) begin
            tests_failed++;
            $display("FAIL gap_rd4: got %08h required 00000000", data_a);
        end
    endtask

    task automatic test_reset_midload();
        logic [7:0] s [6] = '{8'h00, 8'h02, 8'hCA, 8'hFE, 8'hF0, 8'h0D};
        logic [7:0] r [6] = '{8'h00, 8'h01, 8'h34, 8'h01, 8'h00, 8'h05};
        do_reset();
        for (int i = 0; i < 6; i++) send_byte(1'b0, s[i]);
        tests_run++;
        if (words_a !== 16'd1 || done_a !== 1'b0) begin
            tests_failed++;
            $display("FAIL mid_before: words=%0d done=%b required 1 0", words_a, done_a);
        end
        @(negedge clk);
        rst = 1'b0;
        #1;
        tests_run++;
        if ({rdy_a, crst_a, done_a} !== 3'b110 || words_a !== 16'd0) begin
            tests_failed++;
            $display("FAIL mid_reset: rdy/crst/done=%b words=%0d required 110 / 0",
                     {rdy_a, crst_a, done_a}, words_a);
        end
        @(negedge clk);
        rst = 1'b1;
        read_a(1'b1, 32'h0);
        tests_run++;
        if (data_a !== 32'hCAFEF00D) begin
            tests_failed++;
            $display("FAIL mid_kept: got %08h required cafef00d", data_a);
        end
        for (int i = 0; i < 6; i++) send_byte(1'b0, r[i]);
        read_a(1'b1, 32'h0);
        tests_run++;
        if (data_a !== 32'h34010005 || done_a !== 1'b1 || words_a !== 16'd1) begin
            tests_failed++;
            $display("FAIL mid_reload: got %08h done=%b words=%0d required 34010005 1 1",
                     data_a, done_a, words_a);
        end
    endtask

    task automatic test_depth_overflow();
        logic [31:0] exp_w;
        do_reset();
        send_byte(1'b1, 8'h00);
        send_byte(1'b1, 8'h05);
        for (int w = 0; w < 5; w++) begin
            for (int k = 0; k < 4; k++) send_byte(1'b1, 8'hA0 + 8'(w));
            if (w == 3) begin
                tests_run++;
                if (words_b !== 16'd4 || done_b !== 1'b0) begin
                    tests_failed++;
                    $display("FAIL ovf_full: words=%0d done=%b required 4 0", words_b, done_b);
                end
            end
        end
        tests_run++;
        if (words_b !== 16'd4 || done_b !== 1'b1 || crst_b !== 1'b0 || rdy_b !== 1'b0) begin
            tests_failed++;
            $display("FAIL ovf_done: words=%0d done=%b crst=%b rdy=%b required 4 1 0 0",
                     words_b, done_b, crst_b, rdy_b);
        end
        for (int w = 0; w < 4; w++) begin
            @(negedge clk);
            ce_b = 1'b1; addr_b = 32'(w * 4);
            #1;
            exp_w = {4{8'hA0 + 8'(w)}};
            tests_run++;
            if (data_b !== exp_w) begin
                tests_failed++;
                $display("FAIL ovf_rd%0d: got %08h required %08h", w, data_b, exp_w);
            end
        end
        @(negedge clk);
        addr_b = 32'h10;
        #1;
        tests_run++;
        if (data_b !== 32'h0) begin
            tests_failed++;
            $display("FAIL ovf_rd_oob: got %08h required 00000000", data_b);
        end
    endtask

    initial begin
        tests_run = 0; tests_failed = 0;
        ce_a = 1'b0; addr_a = 32'h0; vld_a = 1'b0; byte_a = 8'h00;
        ce_b = 1'b0; addr_b = 32'h0; vld_b = 1'b0; byte_b = 8'h00;
        test_reset();
        test_basic_load();
        test_ce_gate();
        test_empty_header();
        test_gapped_load();
        test_reset_midload();
        test_depth_overflow();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule : tb_inst_rom_loader
